// File: rtl/chacha20_qr_sched.sv
// ChaCha20 round scheduler: owns the 16x32-bit working state, presents one
// quarter-round's worth of words (a,b,c,d) per cycle to an external
// chacha20_qr datapath and writes the results back in place. ROUNDS rounds
// are run as ROUNDS/2 double rounds of 8 steps (4 column + 4 diagonal).
//
// Control semantics (no back-pressure in this block):
//   wr_en / start are single-cycle requests sampled at posedge and accepted
//   only while busy is low. When both are accepted in the same cycle the
//   write commits first, so the rounds start on the updated state. busy and
//   done decode the FSM one-to-one (neither high = IDLE), which is how the
//   controller state is observed from outside.
module chacha20_qr_sched #(
  parameter int ROUNDS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic [3:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic [31:0] qr_a,
  output logic [31:0] qr_b,
  output logic [31:0] qr_c,
  output logic [31:0] qr_d,
  input  logic [31:0] qr_a2,
  input  logic [31:0] qr_b2,
  input  logic [31:0] qr_c2,
  input  logic [31:0] qr_d2
);

  localparam int DR = ROUNDS / 2;
  localparam int CW = (DR > 1) ? $clog2(DR) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t          cur_state;
  fsm_t          nxt_state;
  logic [31:0]   words [16];
  logic [2:0]    step;
  logic [CW-1:0] dr_cnt;
  logic [3:0]    idx_a;
  logic [3:0]    idx_b;
  logic [3:0]    idx_c;
  logic [3:0]    idx_d;
  logic [1:0]    col;
  logic [1:0]    col_b;
  logic [1:0]    col_c;
  logic [1:0]    col_d;
  logic          last_step;

  // Last writeback of the final double round ends the run.
  assign last_step = (cur_state == RUN) && (step == 3'd7) &&
                     (dr_cnt == CW'(DR - 1));

  // Word selection: row r of the 4x4 state holds words 4r..4r+3. Column
  // steps (0..3) take column `col` straight down; diagonal steps (4..7)
  // shift row r right by r columns, modulo 4.
  always_comb begin
    col   = step[1:0];
    col_b = col;
    col_c = col;
    col_d = col;
    if (step[2]) begin
      col_b = col + 2'd1;
      col_c = col + 2'd2;
      col_d = col + 2'd3;
    end
    idx_a = {2'b00, col};
    idx_b = {2'b01, col_b};
    idx_c = {2'b10, col_c};
    idx_d = {2'b11, col_d};
  end

  assign qr_a    = words[idx_a];
  assign qr_b    = words[idx_b];
  assign qr_c    = words[idx_c];
  assign qr_d    = words[idx_d];
  assign rd_data = words[rd_addr];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) cur_state <= IDLE;
    else        cur_state <= nxt_state;
  end

  // FSM next-state: start wins over wr_en when leaving DONE.
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      IDLE:    if (start) nxt_state = RUN;
      RUN:     if (last_step) nxt_state = DONE;
      DONE: begin
        if (start)      nxt_state = RUN;
        else if (wr_en) nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (cur_state == RUN);
    done = (cur_state == DONE);
  end

  // State words, step and double-round counter: writeback during RUN,
  // host writes otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) words[i] <= '0;
      step   <= '0;
      dr_cnt <= '0;
    end else if (cur_state == RUN) begin
      words[idx_a] <= qr_a2;
      words[idx_b] <= qr_b2;
      words[idx_c] <= qr_c2;
      words[idx_d] <= qr_d2;
      step         <= step + 3'd1;
      if (step == 3'd7) begin
        if (last_step) dr_cnt <= '0;
        else           dr_cnt <= dr_cnt + CW'(1);
      end
    end else if (wr_en) begin
      words[wr_addr] <= wr_data;
    end
  end

endmodule
